// File: rtl/ultrasonic_pkg.sv
// Shared types, width helpers and parameter legality checks for the ultrasonic burst scheduler.
package ultrasonic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        LISTEN = 2'd2
    } us_state_e;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned chw(input int unsigned num_ch);
        return cnt_width(num_ch);
    endfunction

    function automatic bit params_legal(
        input int unsigned num_ch,
        input int unsigned half_period,
        input int unsigned num_pulses,
        input int unsigned frame_cyc,
        input int unsigned rt_cyc,
        input int unsigned dead_cyc,
        input bit          dead_en
    );
        bit ok;
        ok = (num_ch >= 1) && (num_ch <= 16);
        ok = ok && (half_period >= 2) && (num_pulses >= 1);
        ok = ok && (frame_cyc > 2 * half_period * num_pulses);
        ok = ok && (rt_cyc > 0) && (rt_cyc < frame_cyc);
        ok = ok && (!dead_en || (dead_cyc < half_period));
        return ok;
    endfunction

endpackage

// File: rtl/ultrasonic_burst_scheduler_carrier.sv
// Carrier generator: half-period counter, phase, pulse count and optional dead-time gating.
// Dead-time gating is compiled in when DEADTIME_EN is defined.
module us_carrier_gen
    import ultrasonic_pkg::*;
#(
    parameter int HALF_PERIOD = 622,
    parameter int NUM_PULSES  = 32,
    parameter int DEAD_CYC    = 4
) (
    input  logic SYS_CLK,
    input  logic RST_N,
    input  logic run,
    output logic hi,
    output logic lo,
    output logic done
);

    localparam int HPW = cnt_width(HALF_PERIOD);
    localparam int PW  = cnt_width(NUM_PULSES);
    localparam logic [HPW-1:0] HP_LAST    = HPW'(HALF_PERIOD - 1);
    localparam logic [HPW-1:0] DEAD_TC    = HPW'(DEAD_CYC);
    localparam logic [PW-1:0]  PULSE_LAST = PW'(NUM_PULSES - 1);
`ifdef DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic           active_q, active_n;
    logic [HPW-1:0] hp_q, hp_n;
    logic           phase_q, phase_n;
    logic [PW-1:0]  pc_q, pc_n;
    logic           gate_n;

    // Registers describe the current burst cycle; a fresh burst loads phase=1 at count 0.
    always_comb begin
        active_n = 1'b0;
        hp_n     = '0;
        phase_n  = 1'b0;
        pc_n     = '0;
        if (run && !active_q) begin
            active_n = 1'b1;
            phase_n  = 1'b1;
        end else if (run) begin
            active_n = 1'b1;
            phase_n  = phase_q;
            pc_n     = pc_q;
            if (hp_q == HP_LAST) begin
                phase_n = ~phase_q;
                if (!phase_q) begin
                    pc_n = pc_q + PW'(1);
                end
            end else begin
                hp_n = hp_q + HPW'(1);
            end
        end
        gate_n = !DEAD_EN || (hp_n >= DEAD_TC);
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            active_q <= 1'b0;
            hp_q     <= '0;
            phase_q  <= 1'b0;
            pc_q     <= '0;
            hi       <= 1'b0;
            lo       <= 1'b0;
        end else begin
            active_q <= active_n;
            hp_q     <= hp_n;
            phase_q  <= phase_n;
            pc_q     <= pc_n;
            hi       <= run && phase_n && gate_n;
            lo       <= run && !phase_n && gate_n;
        end
    end

    assign done = active_q && (hp_q == HP_LAST) && !phase_q && (pc_q == PULSE_LAST);

endmodule

// File: rtl/ultrasonic_burst_scheduler.sv
// Round-robin multi-channel ultrasonic burst scheduler with frame timing and receiver strobes.
// Optional DEADTIME_EN inserts a dead gap after each carrier phase toggle.
//   state  | meaning
//   IDLE   | stopped, all legs low
//   BURST  | active channel driven by the carrier
//   LISTEN | legs low, frame counter running to the next burst
module ultrasonic_burst_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int HALF_PERIOD = 622,
    parameter int NUM_PULSES  = 32,
    parameter int FRAME_CYC   = 1650000,
    parameter int RT_CYC      = 30000,
    parameter int DEAD_CYC    = 4
) (
    input  logic                      SYS_CLK,
    input  logic                      RST_N,
    input  logic                      ON,
    input  logic [NUM_CH-1:0]         chMask,
    output logic                      burstStart,
    output logic                      roundTripFlag,
    output logic [chw(NUM_CH)-1:0]    activeCh,
    output logic                      busy,
    output logic [2*NUM_CH-1:0]       pulseOutput
);

    localparam int CHW = chw(NUM_CH);
    localparam int FW  = cnt_width(FRAME_CYC);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);
    localparam logic [FW-1:0] RT_TC      = FW'(RT_CYC);
`ifdef DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    if (!params_legal(NUM_CH, HALF_PERIOD, NUM_PULSES, FRAME_CYC, RT_CYC, DEAD_CYC, DEAD_EN))
    begin : g_bad_params
        $error("ultrasonic_burst_scheduler: illegal parameter set");
    end

    us_state_e       state_q, state_n;
    logic [FW-1:0]   cnt_q, cnt_n;
    logic [CHW-1:0]  ch_q, ch_n;
    logic            bs_q, bs_n, rt_q, rt_n, busy_q;
    logic            run, car_hi, car_lo, car_done;

    // Circular search for the first set mask bit at or after start.
    function automatic logic [CHW-1:0] next_ch(input logic [NUM_CH-1:0] mask, input int start);
        logic [CHW-1:0] r;
        bit             found;
        int             idx;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (start + i) % NUM_CH;
            if (!found && mask[idx]) begin
                r     = CHW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ch_n    = ch_q;
        bs_n    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ON && (|chMask)) begin
                    state_n = BURST;
                    cnt_n   = '0;
                    ch_n    = next_ch(chMask, 0);
                    bs_n    = 1'b1;
                end
            end
            default: begin
                if (!ON) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_q == FRAME_LAST) begin
                    cnt_n = '0;
                    if (|chMask) begin
                        state_n = BURST;
                        ch_n    = next_ch(chMask, int'(ch_q) + 1);
                        bs_n    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + FW'(1);
                    if (state_q == BURST && car_done) begin
                        state_n = LISTEN;
                    end
                end
            end
        endcase
        rt_n = (state_n != IDLE) && (cnt_n == RT_TC);
        run  = (state_n == BURST);
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            bs_q    <= 1'b0;
            rt_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            ch_q    <= ch_n;
            bs_q    <= bs_n;
            rt_q    <= rt_n;
            busy_q  <= (state_n != IDLE);
        end
    end

    us_carrier_gen #(
        .HALF_PERIOD (HALF_PERIOD),
        .NUM_PULSES  (NUM_PULSES),
        .DEAD_CYC    (DEAD_CYC)
    ) u_carrier (
        .SYS_CLK (SYS_CLK),
        .RST_N   (RST_N),
        .run     (run),
        .hi      (car_hi),
        .lo      (car_lo),
        .done    (car_done)
    );

    // Carrier and channel index are both flops; the demux only steers them.
    always_comb begin
        pulseOutput = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CHW'(c)) begin
                pulseOutput[2*c +: 2] = {car_hi, car_lo};
            end
        end
    end

    assign burstStart    = bs_q;
    assign roundTripFlag = rt_q;
    assign activeCh      = ch_q;
    assign busy          = busy_q;

endmodule
